pump_scheduler: RTL and testbench
=================================

# pump_scheduler

Round-robin scheduler that shares the single irrigation pump among `N_SECT` sector process controllers. Each sector controller raises a request. The scheduler opens that sector's valve, waits for the valve to settle, and then runs the pump. It enforces a minimum and a maximum run time, and it stops the pump and lets it spin down before closing the valve. It sits between the per-sector process FSMs and the pump/valve drivers.

## Interface
Parameters:
- `N_SECT`, 4: number of sectors (2..8).
- `T_DEAD`, 4: valve-settle and pump-spin-down time, in cycles (≥1).
- `T_MIN`, 8: minimum pump run time per grant, in cycles (≥1).
- `T_MAX`, 64: maximum pump run time per grant, in cycles (> `T_MIN`).
- `CW`, 8: width of the internal counter; must hold `T_MAX`.

Ports:
- `Ck`, in, 1: clock, rising edge.
- `Clr_n`, in, 1: asynchronous active-low reset.
- `Req`, in, `N_SECT`: per-sector pump request; level.
- `Done`, in, `N_SECT`: per-sector completion; pulse or level.
- `Valve`, out, `N_SECT`: one-hot valve-open command; registered.
- `Pump`, out, 1: pump enable; registered.
- `Sel`, out, `$clog2(N_SECT)`: index of the granted sector; registered.
- `Busy`, out, 1: high in every state except IDLE.
- `Tout`, out, 1: one-cycle pulse when a grant is ended by `T_MAX`.

## Operation
- States: IDLE, OPEN, RUN, CLOSE. A 2-bit enum holds the state, a `CW`-bit counter times each state, and a pointer register `last` holds the previous grant.
- IDLE: `Valve`=0, `Pump`=0.
  - If any `Req` bit is high, pick the first set bit searching from `last`+1, wrapping modulo `N_SECT`.
  - Load `Sel` and `last` with that index, clear the counter, go to OPEN.
- OPEN: `Valve[Sel]`=1, `Pump`=0. After exactly `T_DEAD` cycles, clear the counter and go to RUN.
- RUN: `Valve[Sel]`=1, `Pump`=1.
  - The release condition is `Done[Sel]`=1 or `Req[Sel]`=0.
  - A release seen before `T_MIN` cycles have elapsed is latched in a flag. It takes effect once the counter reaches `T_MIN`-1.
  - Release taken: go to CLOSE.
  - No release by the time the counter reaches `T_MAX`-1: go to CLOSE and pulse `Tout`.
  - If release and `T_MAX` occur in the same cycle, it counts as a normal completion: `Tout`=0.
- CLOSE: `Pump`=0, `Valve[Sel]` stays 1. After exactly `T_DEAD` cycles, go to IDLE, which drops `Valve`.
- Only the granted sector's `Done` and `Req` are observed. Inputs of other sectors are ignored until the scheduler is back in IDLE.
- `Valve` is always one-hot or zero. `Pump`=1 only in RUN.
- The counter never wraps: it saturates at `T_MAX`-1.

## Timing
- Reset (`Clr_n`=0, asynchronous):
  - State = IDLE.
  - `Valve`=0, `Pump`=0, `Sel`=0, `Busy`=0, `Tout`=0.
  - Counter and release flag = 0.
  - `last`=`N_SECT`-1, so sector 0 has first priority.
- Reset in the middle of a grant drops `Pump` and `Valve` immediately, without dead time. This is accepted.
- Request sampled at edge E0 in IDLE:
  - `Valve` rises after E0.
  - `Pump` rises after E0+`T_DEAD`.
- `Pump` stays high for at least `T_MIN` and at most `T_MAX` cycles.
- `Valve` falls `T_DEAD` cycles after `Pump` falls.
- The scheduler spends at least one IDLE cycle between grants, with `Valve`=0 for that cycle.
- `Tout` is asserted in the cycle CLOSE is entered.

## Structure
- Shared package `pump_sched_pkg` holds:
  - the state enum `pump_state_t` (IDLE, OPEN, RUN, CLOSE);
  - the default timing constants.
- One sub-module, `rr_pick`, is combinational. Inputs are `Req` and `last`; outputs are a `found` flag and the next index. It is instantiated once.
- The rest is a single sequential FSM with the counter.

## Test plan
All scenarios use the default parameters.
- **Reset and single request.** Assert `Req`=0001 after reset; `Done[0]` pulses at RUN cycle 2.
  - `Valve`=0001 at E0+1.
  - `Pump` is high from E0+4 to E0+12 (8 cycles).
  - `Valve` drops at E0+16.
  - `Tout`=0.
- **Timeout.** Hold `Req`=0010 and never assert `Done`.
  - `Pump` is high for exactly 64 cycles.
  - `Tout` pulses once.
  - `Sel`=1 throughout.
  - A second grant to sector 1 follows after 1 IDLE cycle.
- **Round-robin order.** Hold `Req`=1111 with `Done` asserted immediately on each grant.
  - Grant order is 0,1,2,3,0.
  - `Valve` is never multi-hot.
  - `Valve` is 0 for at least 1 cycle between grants.
- **Wrap and skip.** Drive `Req`=1001 with `last`=0 (reached after sector 0 is served).
  - Next grant is 3.
  - The grant after that is 0.
- **Simultaneous release and `T_MAX`.** Assert `Done[0]` in the RUN cycle where the counter equals 63.
  - Transition to CLOSE.
  - `Tout`=0.
- **Reset mid-RUN.** Pull `Clr_n` low while `Pump`=1.
  - `Pump`, `Valve` and `Busy` go to 0 asynchronously.
  - After release, `Req`=0001 is granted to sector 0.

Source files
------------

// File: rtl/pump_sched_pkg.sv
// -----------------------------------------------------------------------------
// pump_sched_pkg
//
// Shared definitions for the irrigation pump scheduler:
//   - pump_state_t : scheduler FSM state (IDLE, OPEN, RUN, CLOSE)
//   - DEF_*        : default timing and sizing constants
// -----------------------------------------------------------------------------
package pump_sched_pkg;

    // IDLE must stay at encoding 0 so that a cleared state register means idle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_RUN   = 2'd2,
        ST_CLOSE = 2'd3
    } pump_state_t;

    localparam int DEF_N_SECT = 4;   // sectors sharing the pump
    localparam int DEF_T_DEAD = 4;   // valve settle / pump spin-down, cycles
    localparam int DEF_T_MIN  = 8;   // minimum pump run per grant, cycles
    localparam int DEF_T_MAX  = 64;  // maximum pump run per grant, cycles
    localparam int DEF_CW     = 8;   // state timer width, must hold DEF_T_MAX

endpackage : pump_sched_pkg

// File: rtl/pump_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//
// Combinational round-robin search. Starting at last+1 and wrapping modulo
// N_SECT, returns the first sector whose request bit is set.
//
// Ports:
//   req   in  [N_SECT-1:0] per-sector request levels
//   last  in  [SW-1:0]     index of the previous grant
//   found out              at least one request is set
//   idx   out [SW-1:0]     index of the chosen sector (0 when found=0)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N_SECT = 4,
    parameter int SW     = $clog2(N_SECT)
) (
    input  logic [N_SECT-1:0] req,
    input  logic [SW-1:0]     last,
    output logic              found,
    output logic [SW-1:0]     idx
);

    int j;

    // Walk the offsets from farthest to nearest so that the nearest set bit
    // (the highest round-robin priority) is the one left in idx.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int i = N_SECT; i >= 1; i--) begin
            j = int'(last) + i;
            if (j >= N_SECT) begin
                j = j - N_SECT;
            end
            if (req[j[SW-1:0]]) begin
                found = 1'b1;
                idx   = j[SW-1:0];
            end
        end
    end

endmodule : rr_pick

// File: rtl/pump_scheduler.sv
// -----------------------------------------------------------------------------
// pump_scheduler
//
// Shares one irrigation pump among N_SECT sector controllers. A grant opens
// the sector valve, waits T_DEAD cycles for it to settle, runs the pump for
// between T_MIN and T_MAX cycles, stops the pump, waits T_DEAD cycles for it
// to spin down and only then closes the valve.
//
// Ports:
//   Ck        in                  clock, rising edge
//   Clr_n     in                  asynchronous active-low reset
//   Req       in  [N_SECT-1:0]    per-sector pump request (level)
//   Done      in  [N_SECT-1:0]    per-sector completion (pulse or level)
//   Valve     out [N_SECT-1:0]    one-hot valve-open command (registered)
//   Pump      out                 pump enable (registered)
//   Sel       out [SW-1:0]        index of the granted sector (registered)
//   Busy      out                 high in every state except IDLE
//   Tout      out                 one-cycle pulse when T_MAX ends a grant
//   Dbg_state out [1:0]           current FSM state (pump_state_t encoding)
//
// There is no handshake: Req/Done are plain levels/pulses sampled on every
// rising edge, and only the granted sector's bits are looked at outside IDLE.
// -----------------------------------------------------------------------------
module pump_scheduler
    import pump_sched_pkg::*;
#(
    parameter int N_SECT = DEF_N_SECT,
    parameter int T_DEAD = DEF_T_DEAD,
    parameter int T_MIN  = DEF_T_MIN,
    parameter int T_MAX  = DEF_T_MAX,
    parameter int CW     = DEF_CW,
    parameter int SW     = $clog2(N_SECT)
) (
    input  logic              Ck,
    input  logic              Clr_n,
    input  logic [N_SECT-1:0] Req,
    input  logic [N_SECT-1:0] Done,
    output logic [N_SECT-1:0] Valve,
    output logic              Pump,
    output logic [SW-1:0]     Sel,
    output logic              Busy,
    output logic              Tout,
    output logic [1:0]        Dbg_state
);

    // Terminal counts: every timed state ends when the counter reaches N-1,
    // so a state timed for N cycles occupies exactly N clock periods.
    localparam logic [CW-1:0] DEAD_M1 = CW'(T_DEAD - 1);
    localparam logic [CW-1:0] MIN_M1  = CW'(T_MIN - 1);
    localparam logic [CW-1:0] MAX_M1  = CW'(T_MAX - 1);
    localparam logic [SW-1:0] LAST_RST = SW'(N_SECT - 1);

    pump_state_t       state;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_inc;
    logic              rel_flag;
    logic [SW-1:0]     last;

    logic              pick_found;
    logic [SW-1:0]     pick_idx;
    logic [N_SECT-1:0] pick_oh;

    logic              release_now;
    logic              release_any;
    logic              min_reached;
    logic              max_reached;

    rr_pick #(
        .N_SECT (N_SECT),
        .SW     (SW)
    ) u_rr_pick (
        .req   (Req),
        .last  (last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        pick_oh           = '0;
        pick_oh[pick_idx] = 1'b1;
    end

    // Release is judged only on the granted sector's own inputs.
    assign release_now = Done[Sel] | ~Req[Sel];
    assign release_any = release_now | rel_flag;
    assign min_reached = (cnt >= MIN_M1);
    assign max_reached = (cnt == MAX_M1);

    // Saturating increment: the counter never wraps past T_MAX-1.
    assign cnt_inc = max_reached ? cnt : cnt + 1'b1;

    assign Busy      = (state != ST_IDLE);
    assign Dbg_state = state;

    always_ff @(posedge Ck or negedge Clr_n) begin
        if (!Clr_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rel_flag <= 1'b0;
            last     <= LAST_RST;
            Sel      <= '0;
            Valve    <= '0;
            Pump     <= 1'b0;
            Tout     <= 1'b0;
        end else begin
            // Tout is a single-cycle pulse; only the timeout branch raises it.
            Tout <= 1'b0;

            case (state)
                ST_IDLE: begin
                    Valve    <= '0;
                    Pump     <= 1'b0;
                    rel_flag <= 1'b0;
                    if (pick_found) begin
                        Sel   <= pick_idx;
                        last  <= pick_idx;
                        cnt   <= '0;
                        Valve <= pick_oh;
                        state <= ST_OPEN;
                    end
                end

                ST_OPEN: begin
                    if (cnt == DEAD_M1) begin
                        cnt      <= '0;
                        rel_flag <= 1'b0;
                        Pump     <= 1'b1;
                        state    <= ST_RUN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RUN: begin
                    if (min_reached && release_any) begin
                        // A release wins over T_MAX in the same cycle, so this
                        // branch is tested first and leaves Tout low.
                        cnt   <= '0;
                        Pump  <= 1'b0;
                        state <= ST_CLOSE;
                    end else if (max_reached) begin
                        cnt   <= '0;
                        Pump  <= 1'b0;
                        Tout  <= 1'b1;
                        state <= ST_CLOSE;
                    end else begin
                        // An early release is remembered until T_MIN is met.
                        cnt      <= cnt_inc;
                        rel_flag <= rel_flag | release_now;
                    end
                end

                ST_CLOSE: begin
                    // Valve stays open while the pump spins down.
                    if (cnt == DEAD_M1) begin
                        cnt      <= '0;
                        rel_flag <= 1'b0;
                        Valve    <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    cnt   <= '0;
                    Valve <= '0;
                    Pump  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : pump_scheduler

// File: tb/tb_pump_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pump_scheduler
//
// Self-checking bench for pump_scheduler with default parameters. Each grant
// is driven by do_grant(): the expected sector comes from a round-robin model
// over the request pattern, and the expected pump run length and timeout are
// computed from the release cycle with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_pump_scheduler;
    import pump_sched_pkg::*;

    localparam int N    = DEF_N_SECT;
    localparam int TD   = DEF_T_DEAD;
    localparam int TMIN = DEF_T_MIN;
    localparam int TMAX = DEF_T_MAX;
    localparam int NEVER = 100000;

    // ---------------- clock / reset ----------------
    logic       Ck    = 1'b0;
    logic       Clr_n = 1'b0;
    logic [3:0] Req   = '0;
    logic [3:0] Done  = '0;
    logic [3:0] Valve;
    logic       Pump;
    logic [1:0] Sel;
    logic       Busy;
    logic       Tout;
    logic [1:0] Dbg_state;

    always #5 Ck = ~Ck;

    pump_scheduler dut (
        .Ck        (Ck),
        .Clr_n     (Clr_n),
        .Req       (Req),
        .Done      (Done),
        .Valve     (Valve),
        .Pump      (Pump),
        .Sel       (Sel),
        .Busy      (Busy),
        .Tout      (Tout),
        .Dbg_state (Dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int model_last = N - 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin reference: first set bit after 'last', wrapping.
    function automatic int model_pick(input logic [3:0] pat, input int last);
        int res;
        bit hit;
        res = -1;
        hit = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!hit && pat[(last + i) % N]) begin
                res = (last + i) % N;
                hit = 1'b1;
            end
        end
        return res;
    endfunction

    // Random traffic on the sectors that are not granted.
    task automatic noise(input logic [1:0] sel, input logic req_bit);
        logic [3:0] r;
        logic [3:0] d;
        r      = 4'($urandom);
        d      = 4'($urandom);
        r[sel] = req_bit;
        d[sel] = 1'b0;
        Req    = r;
        Done   = d;
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge with the DUT in IDLE. rel_j is the RUN-cycle
    // index (counter value) at which the release is presented; by_req selects
    // release by dropping Req instead of pulsing Done.
    task automatic do_grant(input logic [3:0] pat, input int rel_j, input bit by_req);
        int         sel;
        int         exp_len;
        bit         exp_tout;
        int         open_cnt;
        int         m;
        int         close_cnt;
        logic [3:0] exp_oh;

        chk("idle_busy", 32'(Busy), 32'd0);
        chk("idle_valve", 32'(Valve), 32'd0);

        sel        = model_pick(pat, model_last);
        model_last = sel;
        exp_oh     = 4'(1 << sel);

        if (rel_j < TMIN - 1) begin
            exp_len  = TMIN;
            exp_tout = 1'b0;
        end else if (rel_j <= TMAX - 1) begin
            exp_len  = rel_j + 1;
            exp_tout = 1'b0;
        end else begin
            exp_len  = TMAX;
            exp_tout = 1'b1;
        end

        Req  = pat;
        Done = '0;
        @(negedge Ck);

        // OPEN: valve up, pump down for TD cycles
        open_cnt = 0;
        while (Pump !== 1'b1 && open_cnt < 50) begin
            chk("open_valve", 32'(Valve), 32'(exp_oh));
            chk("open_sel", 32'(Sel), 32'(sel));
            chk("open_busy", 32'(Busy), 32'd1);
            open_cnt++;
            noise(2'(sel), 1'b1);
            @(negedge Ck);
        end
        chk("open_len", 32'(open_cnt), 32'(TD));

        // RUN: pump up; present release at cycle rel_j
        m = 0;
        while (Pump === 1'b1 && m < TMAX + 20) begin
            chk("run_valve", 32'(Valve), 32'(exp_oh));
            chk("run_sel", 32'(Sel), 32'(sel));
            chk("run_tout", 32'(Tout), 32'd0);
            noise(2'(sel), by_req ? logic'(m < rel_j) : 1'b1);
            if (!by_req && m == rel_j) Done[sel] = 1'b1;
            m++;
            @(negedge Ck);
        end
        chk("pump_len", 32'(m), 32'(exp_len));
        chk("close_tout", 32'(Tout), 32'(exp_tout));

        // CLOSE: pump down, valve held for TD cycles
        close_cnt = 0;
        while (Valve !== 4'd0 && close_cnt < 50) begin
            chk("close_valve", 32'(Valve), 32'(exp_oh));
            chk("close_pump", 32'(Pump), 32'd0);
            if (close_cnt > 0) chk("close_tout_pulse", 32'(Tout), 32'd0);
            close_cnt++;
            noise(2'(sel), 1'b1);
            @(negedge Ck);
        end
        chk("close_len", 32'(close_cnt), 32'(TD));
        chk("end_busy", 32'(Busy), 32'd0);
        chk("end_tout", 32'(Tout), 32'd0);
    endtask

    task automatic apply_reset();
        Req   = '0;
        Done  = '0;
        Clr_n = 1'b0;
        @(negedge Ck);
        Clr_n = 1'b1;
        model_last = N - 1;
        @(negedge Ck);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int rel;
        int k;

        Clr_n = 1'b0;
        repeat (3) @(negedge Ck);
        chk("rst_valve", 32'(Valve), 32'd0);
        chk("rst_pump", 32'(Pump), 32'd0);
        chk("rst_sel", 32'(Sel), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_tout", 32'(Tout), 32'd0);
        chk("rst_state", 32'(Dbg_state), 32'(ST_IDLE));
        Clr_n = 1'b1;
        @(negedge Ck);

        // single request, Done at RUN cycle 2 -> pump 8 cycles
        do_grant(4'b0001, 2, 1'b0);
        // timeout on sector 1, then sector 1 again after one IDLE cycle
        do_grant(4'b0010, NEVER, 1'b0);
        do_grant(4'b0010, 5, 1'b1);

        // round robin from fresh reset: 0,1,2,3,0
        apply_reset();
        repeat (5) do_grant(4'b1111, 0, 1'b0);
        // last = 0: wrap and skip -> 3 then 0
        do_grant(4'b1001, 0, 1'b1);
        do_grant(4'b1001, 3, 1'b0);
        // release exactly when T_MAX is reached: normal completion
        do_grant(4'b0001, TMAX - 1, 1'b0);
        // release exactly at T_MIN-1 and just before it
        do_grant(4'b0100, TMIN - 1, 1'b1);
        do_grant(4'b0100, TMIN - 2, 1'b1);
        // timeout released by Req drop too late
        do_grant(4'b1000, TMAX, 1'b1);

        // randomized grants
        repeat (20) begin
            case ($urandom_range(0, 3))
                0:       rel = $urandom_range(0, TMIN - 1);
                1:       rel = $urandom_range(TMIN, TMAX - 1);
                2:       rel = TMAX - 1;
                default: rel = TMAX + 10;
            endcase
            do_grant(4'($urandom_range(1, 15)), rel, 1'($urandom_range(0, 1)));
        end

        // reset in the middle of RUN
        Req  = 4'b0100;
        Done = '0;
        k = 0;
        while (Pump !== 1'b1 && k < 50) begin
            @(negedge Ck);
            k++;
        end
        chk("mr_pump_up", 32'(Pump), 32'd1);
        repeat (3) @(negedge Ck);
        Clr_n = 1'b0;
        #1;
        chk("mr_pump", 32'(Pump), 32'd0);
        chk("mr_valve", 32'(Valve), 32'd0);
        chk("mr_busy", 32'(Busy), 32'd0);
        Req = '0;
        @(negedge Ck);
        Clr_n = 1'b1;
        model_last = N - 1;
        @(negedge Ck);
        do_grant(4'b0001, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pump_scheduler
